hazard_sb: RTL
==============

Name: hazard_sb

Overview:
- Parametrised scoreboard-based hazard and forwarding unit for the GP register file.
- Successor to the fixed single-cycle hazard/forward pair.
- Tracks in-flight register writes from EX through WB in a DEPTH-entry shift register. Each entry carries a per-instruction result latency, so the unit can stall ID for multi-cycle loads and select a forwarding source for each of two operands.
- Sits beside stg_id/stg_ex; drives the pipeline stall and the forward mux selects.

Parameters:
- REG_W, 4, GP register index width; NUM_REGS = 2**REG_W.
- DEPTH, 4, tracked post-ID stages (EX, MA, MO, WB); must be >= 2.
- LAT_W, 2, width of the latency field.
- SEL_W, 3, forward select width; must hold DEPTH.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  asynchronous, active-high reset
- iw_id_valid  in  1  ID holds a real instruction
- iw_id_has_src_a  in  1  operand A reads a GP register
- iw_id_src_a  in  REG_W  operand A register index
- iw_id_has_src_b  in  1  operand B reads a GP register
- iw_id_src_b  in  REG_W  operand B register index
- iw_id_tgt_we  in  1  ID instruction writes a GP register
- iw_id_tgt  in  REG_W  destination register index
- iw_id_lat  in  LAT_W  stages after EX before the result is forwardable (0 = ALU, 2 = load)
- iw_flush  in  1  branch taken; kill the ID instruction
- iw_hold  in  1  global freeze (e.g. memory wait)
- ow_stall  out  1  hold IA..ID and insert a bubble into EX
- ow_fwd_sel_a  out  SEL_W  0 = register file; k = forward from entry k-1
- ow_fwd_sel_b  out  SEL_W  same, for operand B
- or_stall_cnt  out  32  stall cycle count; present only with HAZARD_STALL_CNT_EN

Behaviour:
- State: entries E[0..DEPTH-1], each {v, we, reg, lat}. E[0] is the instruction in EX; E[DEPTH-1] is the instruction in WB.
- Reset: all v=0, we=0, reg=0, lat=0; or_stall_cnt=0. With no valid entries, ow_stall=0 and both ow_fwd_sel=0.
- Latency saturation: on insert, lat saturates to DEPTH-1 if iw_id_lat > DEPTH-1.
- Match per operand (combinational):
  - Consider operand s only if iw_id_valid & has_src.
  - Find the lowest k with E[k].v & E[k].we & E[k].reg == src; the youngest writer wins.
  - No match: sel = 0, no hazard.
  - Match with k >= E[k].lat: sel = k+1, no hazard.
  - Match with k < E[k].lat: hazard; sel is don't-care and driven 0.
- ow_stall = hazard_a | hazard_b. Combinational, same cycle as the ID inputs; no registered latency.
- Clock edge, iw_hold=1: E is unchanged; the stall counter is unchanged.
- Clock edge, iw_hold=0:
  - Shift: E[k] <= E[k-1] for k = 1..DEPTH-1; the entry leaving E[DEPTH-1] is retired.
  - Insert into E[0]: the new instruction if iw_id_valid & ~ow_stall & ~iw_flush, else a bubble (v=0).
- Flush and stall together: flush wins (bubble inserted); ow_stall may still read 1 and is ignored by the pipeline.
- Flush does not clear E[0..DEPTH-1]. The branch itself sits in EX and completes.
- A load-use with lat=2 directly behind the load stalls 2 cycles, then forwards with sel = 3 (MO).
- Same register written by two in-flight instructions: the younger entry is always selected.
- iw_id_tgt_we=0 inserts an entry with we=0, which never matches.
- Reset asserted mid-operation clears all entries immediately (asynchronous); the first edge after release inserts normally.

Optional Feature:
HAZARD_STALL_CNT_EN
- Defined: or_stall_cnt is a 32-bit counter.
  - Increments on each clock edge with iw_hold=0 & ow_stall=1 & ~iw_flush.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then ID reads r3 with no writers -> ow_stall=0, fwd_sel_a=0; all entries invalid.
- ALU r5 (lat 0) inserted; next cycle ID reads r5 on A -> stall=0, fwd_sel_a=1. One cycle later -> sel=2. After DEPTH cycles -> sel=0.
- Load r2 (lat 2); next ID reads r2 on B -> stall=1 for 2 cycles, then sel_b=3. With HAZARD_STALL_CNT_EN, or_stall_cnt=2.
- Two writers of r7 (ALU then ALU); ID reads r7 -> sel selects the younger (sel=1), not 2.
- Load r4 in EX; ID reads r4 with iw_flush=1 -> bubble inserted, E[1] holds the load next cycle, counter unchanged.
- iw_hold=1 for 3 cycles during a load-use stall -> entries frozen and stall stays 1. Release -> stall clears after the remaining latency; asynchronous reset mid-stall -> stall=0 immediately.

Source files
------------

// File: rtl/hazard_sb.sv
// Scoreboard hazard/forwarding unit: tracks in-flight GP writes EX..WB, stalls ID and picks forward sources.
// Optional stall-cycle counter on or_stall_cnt when HAZARD_STALL_CNT_EN is defined.
module hazard_sb #(
  parameter int REG_W = 4,
  parameter int DEPTH = 4,
  parameter int LAT_W = 2,
  parameter int SEL_W = 3
) (
  input  logic             iw_clk,
  input  logic             iw_rst,
  input  logic             iw_id_valid,
  input  logic             iw_id_has_src_a,
  input  logic [REG_W-1:0] iw_id_src_a,
  input  logic             iw_id_has_src_b,
  input  logic [REG_W-1:0] iw_id_src_b,
  input  logic             iw_id_tgt_we,
  input  logic [REG_W-1:0] iw_id_tgt,
  input  logic [LAT_W-1:0] iw_id_lat,
  input  logic             iw_flush,
  input  logic             iw_hold,
  output logic             ow_stall,
  output logic [SEL_W-1:0] ow_fwd_sel_a,
  output logic [SEL_W-1:0] ow_fwd_sel_b
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      or_stall_cnt
`endif
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [REG_W-1:0] tgt_q [DEPTH];
  logic [REG_W-1:0] tgt_d [DEPTH];
  logic [LAT_W-1:0] lat_q [DEPTH];
  logic [LAT_W-1:0] lat_d [DEPTH];

  logic             hazard_a, hazard_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic [LAT_W-1:0] lat_ins;
  logic             insert;

  // Returns {hazard, sel}; the scan keeps the lowest (youngest) matching writer.
  function automatic logic [SEL_W:0] match(input logic en, input logic [REG_W-1:0] src);
    logic             found;
    logic [SEL_W:0]   res;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (en && !found && v_q[k] && we_q[k] && tgt_q[k] == src) begin
        found = 1'b1;
        if (k < int'(lat_q[k])) res = {1'b1, {SEL_W{1'b0}}};
        else                    res = {1'b0, SEL_W'(k + 1)};
      end
    end
    return res;
  endfunction

  always_comb begin
    {hazard_a, sel_a} = match(iw_id_valid & iw_id_has_src_a, iw_id_src_a);
    {hazard_b, sel_b} = match(iw_id_valid & iw_id_has_src_b, iw_id_src_b);
  end

  assign ow_stall     = hazard_a | hazard_b;
  assign ow_fwd_sel_a = sel_a;
  assign ow_fwd_sel_b = sel_b;

  assign lat_ins = (int'(iw_id_lat) > DEPTH - 1) ? LAT_W'(DEPTH - 1) : iw_id_lat;
  assign insert  = iw_id_valid & ~ow_stall & ~iw_flush;

  always_comb begin
    v_d  = v_q;
    we_d = we_q;
    tgt_d = tgt_q;
    lat_d = lat_q;
    if (!iw_hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        v_d[k]   = v_q[k-1];
        we_d[k]  = we_q[k-1];
        tgt_d[k] = tgt_q[k-1];
        lat_d[k] = lat_q[k-1];
      end
      v_d[0]   = insert;
      we_d[0]  = insert & iw_id_tgt_we;
      tgt_d[0] = insert ? iw_id_tgt : '0;
      lat_d[0] = insert ? lat_ins : '0;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      v_q  <= '0;
      we_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tgt_q[k] <= '0;
        lat_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      tgt_q <= tgt_d;
      lat_q <= lat_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Flushed stalls are not real stall cycles; the pipeline ignores them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!iw_hold && ow_stall && !iw_flush) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign or_stall_cnt = stall_cnt_q;
`endif

endmodule
